// File: rtl/svm_dot_acc.sv
// SVM dot-product accumulator: pops packed {feature, weight} words from the ROM-data FIFO,
// multiplies each signed pair and accumulates onto a bias with saturation.
module svm_dot_acc #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [LEN_W-1:0]  cfg_num_words,
    input  logic [31:0]       cfg_bias,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_pop,
    output logic              busy,
    output logic              result_vld,
    input  logic              result_rdy,
    output logic [ACC_W-1:0]  result_data,
    output logic              result_class,
    output logic              sat_flag
);

    localparam int HALF_W = DATA_W / 2;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state;
    logic [LEN_W-1:0]         remaining;
    logic signed [ACC_W-1:0]  acc;
    logic                     p0_vld;
    logic                     s1_vld;
    logic                     s2_vld;
    logic signed [HALF_W-1:0] s1_feature;
    logic signed [HALF_W-1:0] s1_weight;
    logic signed [DATA_W-1:0] s2_prod;

    logic signed [DATA_W-1:0] prod;
    logic signed [ACC_W:0]    sum_wide;
    logic                     add_ovf;
    logic signed [ACC_W-1:0]  acc_add;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     sat_hit;
    logic signed [ACC_W-1:0]  bias_ext;
    logic                     start_ok;

    assign start_ok = (state == IDLE) && cfg_start;
    assign bias_ext = {{(ACC_W-32){cfg_bias[31]}}, cfg_bias};
    assign fifo_pop = (state == RUN) && !fifo_empty && (remaining != '0);

    assign prod = s1_feature * s1_weight;

    // One guard bit detects signed overflow of the accumulate; clamp toward the overflow direction.
    assign sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W-DATA_W+1){s2_prod[DATA_W-1]}}, s2_prod};
    assign add_ovf  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    assign acc_add  = add_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
    assign acc_next = s2_vld ? acc_add : acc;
    assign sat_hit  = s2_vld && add_ovf;

    // p0_vld marks the cycle in which fifo_rd_data carries the word popped one cycle earlier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_vld     <= 1'b0;
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
            s1_feature <= '0;
            s1_weight  <= '0;
            s2_prod    <= '0;
        end else begin
            p0_vld <= fifo_pop;
            s1_vld <= p0_vld;
            s2_vld <= s1_vld;
            if (p0_vld) begin
                s1_feature <= fifo_rd_data[DATA_W-1:HALF_W];
                s1_weight  <= fifo_rd_data[HALF_W-1:0];
            end
            if (s1_vld) begin
                s2_prod <= prod;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            sat_flag <= 1'b0;
        end else if (start_ok) begin
            acc      <= bias_ext;
            sat_flag <= 1'b0;
        end else begin
            acc <= acc_next;
            if (sat_hit) begin
                sat_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            busy         <= 1'b0;
            result_vld   <= 1'b0;
            result_data  <= '0;
            result_class <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        remaining <= cfg_num_words;
                        busy      <= 1'b1;
                        if (cfg_num_words == '0) begin
                            state        <= DONE;
                            result_vld   <= 1'b1;
                            result_data  <= bias_ext;
                            result_class <= ~cfg_bias[31];
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fifo_pop) begin
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Once nothing is left upstream of stage 2, this edge commits the final add.
                    if (!p0_vld && !s1_vld) begin
                        state        <= DONE;
                        result_vld   <= 1'b1;
                        result_data  <= acc_next;
                        result_class <= ~acc_next[ACC_W-1];
                    end
                end
                DONE: begin
                    if (result_rdy) begin
                        result_vld <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_svm_dot_acc.sv
// Scoreboard bench for svm_dot_acc: a FIFO model feeds words, a reference sum with clamping
// is queued at each start and compared when result_vld rises.
module tb_svm_dot_acc;

    localparam int  ACC_W   = 40;
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_start;
    logic [15:0]       cfg_num_words;
    logic [31:0]       cfg_bias;
    logic              fifo_empty;
    logic [31:0]       fifo_rd_data;
    logic              fifo_pop;
    logic              busy;
    logic              result_vld;
    logic              result_rdy;
    logic [ACC_W-1:0]  result_data;
    logic              result_class;
    logic              sat_flag;

    svm_dot_acc #(.DATA_W(32), .ACC_W(ACC_W), .LEN_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_num_words(cfg_num_words),
        .cfg_bias     (cfg_bias),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_pop     (fifo_pop),
        .busy         (busy),
        .result_vld   (result_vld),
        .result_rdy   (result_rdy),
        .result_data  (result_data),
        .result_class (result_class),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        bit     cls;
        bit     sat;
        int     npops;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stim_q[$];
    logic [31:0] feed_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pops_op = 0;
    int          last_pop_cyc = 0;
    int          start_cyc = 0;
    int          op_num = 0;
    bit          gap_mode = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] pend_word = '0;
    bit          vld_prev = 1'b0;

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Reference dot product: 64-bit running sum clamped to the ACC_W signed range after each add.
    task automatic model(input int n, input logic [31:0] bias, output exp_t e);
        longint a;
        logic signed [15:0] f;
        logic signed [15:0] w;
        logic [31:0] word;
        a = longint'($signed(bias));
        e.sat = 1'b0;
        for (int i = 0; i < n; i++) begin
            word = stim_q[i];
            f = word[31:16];
            w = word[15:0];
            a = a + longint'(f) * longint'(w);
            if (a > ACC_MAX) begin a = ACC_MAX; e.sat = 1'b1; end
            if (a < ACC_MIN) begin a = ACC_MIN; e.sat = 1'b1; end
        end
        e.data  = a;
        e.cls   = (a >= 0);
        e.npops = n;
    endtask

    // FIFO model: pop observed mid-cycle, data presented for the whole following cycle.
    always @(negedge clk) begin
        if (!reset && fifo_pop) begin
            check("pop_not_empty", fifo_empty, 0);
            check("feed_avail", feed_q.size() > 0, 1);
            if (feed_q.size() > 0) pend_word = feed_q.pop_front();
            pend = 1'b1;
            pops_op++;
            last_pop_cyc = cyc;
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (pend) begin
            fifo_rd_data = pend_word;
            pend = 1'b0;
        end else begin
            fifo_rd_data = 32'hA5A5_5A5A;
        end
        fifo_empty = (feed_q.size() == 0) || (gap_mode && cyc[0]);
    end

    // Result monitor: pop the scoreboard on each rising result_vld.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (reset) begin
            vld_prev = 1'b0;
        end else begin
            if (result_vld && !vld_prev) begin
                check("exp_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    op_num++;
                    $display("op %0d: result_data=%0d class=%0b sat=%0b pops=%0d", op_num,
                             $signed(result_data), result_class, sat_flag, pops_op);
                    check("result_data", 64'($signed(result_data)), e.data);
                    check("result_class", result_class, e.cls);
                    check("sat_flag", sat_flag, e.sat);
                    check("pop_count", pops_op, e.npops);
                    // Zero-length: valid the cycle after start. Otherwise s1, s2 and the add
                    // take the three edges after the edge accepting the last pop.
                    lat = (e.npops == 0) ? cyc - start_cyc : cyc - last_pop_cyc;
                    check("latency", lat, (e.npops == 0) ? 1 : 4);
                end
            end
            vld_prev = result_vld;
        end
    end

    task automatic start_op(input int n, input logic [31:0] bias);
        @(posedge clk);
        #1;
        pops_op       = 0;
        start_cyc     = cyc;
        cfg_num_words = 16'(n);
        cfg_bias      = bias;
        cfg_start     = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic run_op(input int n, input logic [31:0] bias, input bit gap);
        exp_t e;
        bit   done;
        bit   busy_drop;
        model(n, bias, e);
        exp_q.push_back(e);
        feed_q    = stim_q;
        gap_mode  = gap;
        done      = 1'b0;
        busy_drop = 1'b0;
        start_op(n, bias);
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (!busy) busy_drop = 1'b1;
            if (result_vld && result_rdy) done = 1'b1;
        end
        check("op_done", done, 1);
        check("busy_held", busy_drop, 0);
        @(posedge clk);
        #1;
        check("busy_cleared", busy, 0);
        check("vld_cleared", result_vld, 0);
        gap_mode = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e6;
        bit   seen;
        reset         = 1'b1;
        cfg_start     = 1'b0;
        cfg_num_words = '0;
        cfg_bias      = '0;
        result_rdy    = 1'b1;
        fifo_empty    = 1'b1;
        fifo_rd_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pop", fifo_pop, 0);
        check("rst_busy", busy, 0);
        check("rst_vld", result_vld, 0);
        check("rst_data", result_data, 0);
        check("rst_class", result_class, 0);
        check("rst_sat", sat_flag, 0);
        reset = 1'b0;

        stim_q = '{32'h0003_FFFE};
        run_op(1, 32'd0, 1'b0);

        stim_q = '{32'h000A_000A, 32'h0014_000A, 32'h0005_FFF6, 32'h0007_0001};
        run_op(4, -32'sd300, 1'b0);
        run_op(4, 32'd0, 1'b0);

        stim_q = {};
        for (int i = 0; i < 8; i++) stim_q.push_back($urandom);
        run_op(8, $urandom, 1'b1);

        stim_q = {};
        run_op(0, 32'd5, 1'b0);

        stim_q = {};
        for (int i = 0; i < 600; i++) stim_q.push_back(32'h8000_8000);
        run_op(600, 32'd0, 1'b0);
        stim_q = {};
        for (int i = 0; i < 600; i++) stim_q.push_back(32'h8000_7FFF);
        run_op(600, 32'd0, 1'b0);

        // Hold the result with rdy low; starts pulsed in DONE must be ignored.
        stim_q = '{32'h000A_000A, 32'h0014_000A, 32'h0005_FFF6, 32'h0007_0001};
        model(4, -32'sd300, e6);
        exp_q.push_back(e6);
        feed_q     = stim_q;
        result_rdy = 1'b0;
        start_op(4, -32'sd300);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (result_vld) seen = 1'b1;
        end
        check("hold_seen", seen, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            cfg_start     = (i == 3);
            cfg_num_words = 16'd0;
            cfg_bias      = 32'd99;
            @(negedge clk);
            check("hold_data", 64'($signed(result_data)), e6.data);
            check("hold_vld", result_vld, 1);
        end
        @(posedge clk);
        #1;
        result_rdy = 1'b1;
        cfg_start  = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        check("rdy_busy_drop", busy, 0);
        check("rdy_vld_drop", result_vld, 0);
        check("held_after_take", 64'($signed(result_data)), e6.data);
        @(posedge clk);
        #1;
        check("start_in_done_ignored", busy, 0);

        // Reset in the middle of a run: everything clears at once, no result.
        stim_q = {};
        for (int i = 0; i < 8; i++) stim_q.push_back(32'h0001_0001);
        feed_q = stim_q;
        start_op(8, 32'd7);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (pops_op >= 3) seen = 1'b1;
        end
        check("mid_run_reached", seen, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        feed_q.delete();
        pend = 1'b0;
        check("abort_pop", fifo_pop, 0);
        check("abort_busy", busy, 0);
        check("abort_vld", result_vld, 0);
        check("abort_data", result_data, 0);
        check("abort_class", result_class, 0);
        check("abort_sat", sat_flag, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        stim_q = '{32'h0003_FFFE, 32'hFFFF_0005};
        run_op(2, 32'd20, 1'b1);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
